// File: rtl/norm_result_collector.sv
// Collects four-lane quotient vectors into a small FIFO and serialises them A,B,C,D on one stream.
// Optional NORM_COLLECT_DROPCNT_EN adds an 8-bit saturating dropped-vector counter o_drop_cnt.
module norm_result_collector #(
    parameter int unsigned DATAWIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned EW        = 2 * DATAWIDTH + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid_A,
    input  logic          i_valid_B,
    input  logic          i_valid_C,
    input  logic          i_valid_D,
    input  logic [EW-1:0] i_data_A,
    input  logic [EW-1:0] i_data_B,
    input  logic [EW-1:0] i_data_C,
    input  logic [EW-1:0] i_data_D,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [EW-1:0] o_data,
    output logic [1:0]    o_idx,
    output logic          o_last,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_overflow,
`ifdef NORM_COLLECT_DROPCNT_EN
    output logic [7:0]    o_drop_cnt,
`endif
    output logic          o_misalign
);

    localparam int unsigned PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FullCnt = (PW + 1)'(FIFO_DEPTH);

    typedef logic [3:0][EW-1:0] entry_t;

    entry_t        mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          ovf_q, ovf_d;
    logic          mis_q, mis_d;

    logic [3:0] lane_v;
    logic       push, partial, full, empty, xfer, pop, wr_en, drop;

    assign lane_v  = {i_valid_A, i_valid_B, i_valid_C, i_valid_D};
    assign push    = &lane_v;
    assign partial = (|lane_v) & ~push;
    assign full    = (cnt_q == FullCnt);
    assign empty   = (cnt_q == '0);
    assign xfer    = ~empty & i_ready;
    assign pop     = xfer & (idx_q == 2'd3);
    // A push into a full FIFO still fits when the head is popped on the same edge.
    assign wr_en   = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q | drop;
        mis_d    = mis_q | partial;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (xfer) begin
            idx_d = idx_q + 2'd1;
        end
        unique case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + (PW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (PW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ovf_q    <= ovf_d;
            mis_q    <= mis_d;
        end
    end

    // Entry storage needs no reset: it is only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {i_data_D, i_data_C, i_data_B, i_data_A};
        end
    end

`ifdef NORM_COLLECT_DROPCNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    // Drops are reported only through the sticky o_overflow flag.
`endif

    assign o_valid    = ~empty;
    assign o_data     = empty ? '0 : mem_q[rd_ptr_q][idx_q];
    assign o_idx      = idx_q;
    assign o_last     = (idx_q == 2'd3);
    assign o_full     = full;
    assign o_empty    = empty;
    assign o_overflow = ovf_q;
    assign o_misalign = mis_q;

endmodule

// File: tb/tb_norm_result_collector.sv
// Directed bench for norm_result_collector: vector table plus hand sequences for FIFO corners.
module tb_norm_result_collector;

    localparam int unsigned EW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_valid_A = 1'b0, i_valid_B = 1'b0, i_valid_C = 1'b0, i_valid_D = 1'b0;
    logic [EW-1:0] i_data_A = '0, i_data_B = '0, i_data_C = '0, i_data_D = '0;
    logic          i_ready = 1'b0;
    logic          o_valid, o_last, o_full, o_empty, o_overflow, o_misalign;
    logic [EW-1:0] o_data;
    logic [1:0]    o_idx;
`ifdef NORM_COLLECT_DROPCNT_EN
    logic [7:0]    o_drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    norm_result_collector #(
        .DATAWIDTH (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid_A (i_valid_A),
        .i_valid_B (i_valid_B),
        .i_valid_C (i_valid_C),
        .i_valid_D (i_valid_D),
        .i_data_A  (i_data_A),
        .i_data_B  (i_data_B),
        .i_data_C  (i_data_C),
        .i_data_D  (i_data_D),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_idx     (o_idx),
        .o_last    (o_last),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_overflow(o_overflow),
`ifdef NORM_COLLECT_DROPCNT_EN
        .o_drop_cnt(o_drop_cnt),
`endif
        .o_misalign(o_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    vmask;
        logic          rdy;
        logic [EW-1:0] base;
        logic          ev;
        logic [EW-1:0] edata;
        logic [1:0]    eidx;
        logic          elast, efull, eempty, eovf, emis;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane k of vector with base b carries b + (k+1)*0x100.
    task automatic drive(input logic [3:0] mask, input logic [EW-1:0] base, input logic rdy);
        {i_valid_A, i_valid_B, i_valid_C, i_valid_D} = mask;
        i_data_A = base + 18'h100;
        i_data_B = base + 18'h200;
        i_data_C = base + 18'h300;
        i_data_D = base + 18'h400;
        i_ready  = rdy;
    endtask

    task automatic addv(input logic [3:0] m, input logic r, input logic [EW-1:0] b,
                        input logic ev, input logic [EW-1:0] ed, input logic [1:0] ei,
                        input logic el, input logic ef, input logic ee, input logic eo,
                        input logic em);
        vec_t v;
        v.vmask = m; v.rdy = r; v.base = b; v.ev = ev; v.edata = ed; v.eidx = ei;
        v.elast = el; v.efull = ef; v.eempty = ee; v.eovf = eo; v.emis = em;
        tbl.push_back(v);
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [EW-1:0] ed,
                           input logic [1:0] ei, input logic el, input logic ef,
                           input logic ee, input logic eo, input logic em);
        chk({tag, ".valid"}, 32'(o_valid), 32'(ev));
        chk({tag, ".data"}, 32'(o_data), 32'(ed));
        chk({tag, ".idx"}, 32'(o_idx), 32'(ei));
        chk({tag, ".last"}, 32'(o_last), 32'(el));
        chk({tag, ".full"}, 32'(o_full), 32'(ef));
        chk({tag, ".empty"}, 32'(o_empty), 32'(ee));
        chk({tag, ".overflow"}, 32'(o_overflow), 32'(eo));
        chk({tag, ".misalign"}, 32'(o_misalign), 32'(em));
    endtask

    // Checks and consumes the four beats of vector k (base k*0x1000), i_ready held high.
    task automatic drain_vec(input string tag, input int k);
        logic [EW-1:0] exp;
        drive(4'b0000, '0, 1'b1);
        for (int l = 0; l < 4; l++) begin
            exp = EW'(k * 32'h1000 + (l + 1) * 32'h100);
            chk($sformatf("%s.v%0d.l%0d.valid", tag, k, l), 32'(o_valid), 32'd1);
            chk($sformatf("%s.v%0d.l%0d.data", tag, k, l), 32'(o_data), 32'(exp));
            chk($sformatf("%s.v%0d.l%0d.idx", tag, k, l), 32'(o_idx), 32'(l));
            chk($sformatf("%s.v%0d.l%0d.last", tag, k, l), 32'(o_last), 32'(l == 3));
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(4'b0000, '0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Single push, backpressure on idx 1, pipelined pushes, misalign.
        addv(4'hF, 1, 18'h0,  1, 18'h100, 0, 0, 0, 0, 0, 0);
        addv(4'h0, 1, 18'h0,  1, 18'h200, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) addv(4'h0, 0, 18'h0, 1, 18'h200, 1, 0, 0, 0, 0, 0);
        addv(4'h0, 1, 18'h0,  1, 18'h300, 2, 0, 0, 0, 0, 0);
        addv(4'h0, 1, 18'h0,  1, 18'h400, 3, 1, 0, 0, 0, 0);
        addv(4'h0, 1, 18'h0,  0, 18'h0,   0, 0, 0, 1, 0, 0);
        addv(4'hF, 1, 18'h10, 1, 18'h110, 0, 0, 0, 0, 0, 0);
        addv(4'h0, 1, 18'h0,  1, 18'h210, 1, 0, 0, 0, 0, 0);
        addv(4'h0, 1, 18'h0,  1, 18'h310, 2, 0, 0, 0, 0, 0);
        addv(4'hF, 1, 18'h20, 1, 18'h410, 3, 1, 0, 0, 0, 0);
        addv(4'h0, 1, 18'h0,  1, 18'h120, 0, 0, 0, 0, 0, 0);
        addv(4'h0, 1, 18'h0,  1, 18'h220, 1, 0, 0, 0, 0, 0);
        addv(4'h0, 1, 18'h0,  1, 18'h320, 2, 0, 0, 0, 0, 0);
        addv(4'h0, 1, 18'h0,  1, 18'h420, 3, 1, 0, 0, 0, 0);
        addv(4'h0, 1, 18'h0,  0, 18'h0,   0, 0, 0, 1, 0, 0);
        addv(4'hA, 1, 18'h0,  0, 18'h0,   0, 0, 0, 1, 0, 1);
        addv(4'h0, 1, 18'h0,  0, 18'h0,   0, 0, 0, 1, 0, 1);

        do_reset();
        chk_all("reset", 0, '0, 0, 0, 0, 1, 0, 0);
        tick();
        chk_all("post_release", 0, '0, 0, 0, 0, 1, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].vmask, tbl[i].base, tbl[i].rdy);
            tick();
            chk_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].edata, tbl[i].eidx,
                    tbl[i].elast, tbl[i].efull, tbl[i].eempty, tbl[i].eovf, tbl[i].emis);
        end

        // Overflow: five pushes into a depth-4 FIFO with no drain.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(4'hF, EW'(k * 32'h1000), 1'b0);
            tick();
            if (k == 4) begin
                chk("ovf.full_after4", 32'(o_full), 32'd1);
                chk("ovf.ovf_after4", 32'(o_overflow), 32'd0);
            end
        end
        chk("ovf.full_after5", 32'(o_full), 32'd1);
        chk("ovf.ovf_after5", 32'(o_overflow), 32'd1);
`ifdef NORM_COLLECT_DROPCNT_EN
        chk("ovf.drop_cnt", 32'(o_drop_cnt), 32'd1);
`endif
        for (int k = 1; k <= 4; k++) drain_vec("ovf", k);
        chk("ovf.empty_end", 32'(o_empty), 32'd1);
        chk("ovf.valid_end", 32'(o_valid), 32'd0);
        chk("ovf.sticky", 32'(o_overflow), 32'd1);

        // Full FIFO with a push landing on the idx==3 transfer.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive(4'hF, EW'(k * 32'h1000), 1'b0);
            tick();
        end
        chk("sim.full", 32'(o_full), 32'd1);
        drive(4'h0, '0, 1'b1);
        tick();
        tick();
        tick();
        chk("sim.idx3", 32'(o_idx), 32'd3);
        drive(4'hF, EW'(6 * 32'h1000), 1'b1);
        tick();
        chk("sim.full_kept", 32'(o_full), 32'd1);
        chk("sim.no_ovf", 32'(o_overflow), 32'd0);
        chk("sim.idx0", 32'(o_idx), 32'd0);
`ifdef NORM_COLLECT_DROPCNT_EN
        chk("sim.drop_cnt", 32'(o_drop_cnt), 32'd0);
`endif
        drain_vec("sim", 2);
        drain_vec("sim", 3);
        drain_vec("sim", 4);
        drain_vec("sim", 6);
        chk("sim.empty_end", 32'(o_empty), 32'd1);

        // Asynchronous reset while serialising idx 2.
        drive(4'hF, EW'(7 * 32'h1000), 1'b1);
        tick();
        drive(4'h0, '0, 1'b1);
        tick();
        tick();
        chk("mid.idx2", 32'(o_idx), 32'd2);
        #2 rst = 1'b0;
        #1;
        chk_all("mid.async", 0, '0, 0, 0, 0, 1, 0, 0);
        tick();
        rst = 1'b1;
        drive(4'hF, EW'(8 * 32'h1000), 1'b1);
        tick();
        drive(4'h0, '0, 1'b0);
        chk_all("mid.fresh", 1, 18'h8100, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/norm_result_collector.md
# norm_result_collector

Output stage of the vector-normalisation pipeline. Captures the four per-lane quotients (A, B, C, D) from the pipeline's divider outputs when all four lane valids assert together, and buffers whole vectors in a small FIFO. It then serialises each vector onto a single valid/ready stream, one element per beat in A, B, C, D order. It reports full, empty, overflow (vector dropped) and lane-misalignment conditions.

## Interface
Parameters:
- DATAWIDTH, 8, pipeline input width; element width EW = 2*DATAWIDTH+2 (18 at default)
- FIFO_DEPTH, 4, number of whole vectors buffered; power of two, >= 2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_valid_A / i_valid_B / i_valid_C / i_valid_D  in  1 each  per-lane quotient valid
- i_data_A / i_data_B / i_data_C / i_data_D  in  EW each  per-lane quotient
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream ready
- o_data  out  EW  current element
- o_idx  out  2  lane index of current element: 0=A, 1=B, 2=C, 3=D
- o_last  out  1  high when o_idx==3
- o_full  out  1  vector count == FIFO_DEPTH
- o_empty  out  1  vector count == 0
- o_overflow  out  1  sticky; a vector was dropped
- o_misalign  out  1  sticky; lane valids disagreed in some cycle

## Operation
- Push: when all four i_valid_* are high in a cycle, the cycle is a push. {A,B,C,D} is written as one FIFO entry at the clock edge.
- Partial valid: 1 to 3 lane valids high means no write. o_misalign sets at the next edge.
- Push while full: the vector is dropped and o_overflow sets at the next edge. The exception is the simultaneous-pop case below.
- Storage: write pointer, read pointer and vector count are log2(FIFO_DEPTH) and log2(FIFO_DEPTH)+1 bits wide. Pointers wrap modulo FIFO_DEPTH.
- Serialiser state is a 2-bit beat counter, idx:
  - o_valid = !o_empty.
  - o_data = head entry lane[idx], driven combinationally from registered state.
  - o_idx = idx.
- Beat transfer occurs when o_valid && i_ready.
  - On transfer with idx<3: idx increments.
  - On transfer with idx==3: idx returns to 0, the read pointer advances and the entry is popped.
- o_data, o_idx and o_last are held stable while o_valid && !i_ready.
- Simultaneous push and pop in one cycle: count unchanged. This holds when full: the push is accepted, with no overflow, because the popped slot is freed in the same edge.
- Sticky flags are cleared only by reset.

## Timing
- Reset (rst low, asynchronous) drives o_valid=0, o_data=0, o_idx=0, o_last=0, o_full=0, o_empty=1, o_overflow=0 and o_misalign=0. Pointers, count and idx are also 0.
- Assertion mid-burst discards all buffered vectors and any partial serialisation. After release the block behaves as fresh.
- Latency: for a push at edge N into an empty FIFO, o_valid is high in the cycle after edge N. Element A is presented first.
- Throughput: one element per cycle with i_ready held high. A steady input of one vector per 4 cycles never overflows.
- o_full, o_empty, o_overflow and o_misalign are registered and reflect state after the latest edge.

## Configuration
- NORM_COLLECT_DROPCNT_EN defined:
  - Adds output o_drop_cnt, 8 bits, reset 0.
  - It increments once per dropped vector and saturates at 255.
- Not defined:
  - The port and counter are absent.
  - Only the sticky o_overflow reports drops.

## Test plan
- Reset and empty check: hold rst low, then release. Required: o_empty=1, o_valid=0, o_idx=0, all flags 0.
- Single push: push A=0x00100, B=0x00200, C=0x00300, D=0x00400 with i_ready=1. Required next 4 cycles: o_data 0x00100, 0x00200, 0x00300, 0x00400; o_idx 0..3; o_last only on the 4th beat; then o_empty=1.
- Backpressure: i_ready=0 for 5 cycles on beat idx=1. Required: o_data=0x00200 and o_idx=1 held stable; resumes with idx=2 after i_ready=1.
- Overflow (FIFO_DEPTH=4):
  - Push 5 vectors with i_ready=0. Required: o_full=1 after the 4th push, o_overflow=1 after the 5th.
  - Draining yields exactly the first 4 vectors in order.
  - With NORM_COLLECT_DROPCNT_EN, o_drop_cnt=1.
- Full plus simultaneous push and pop: with the FIFO full, push during the idx==3 transfer. Required: o_overflow stays 0, o_full stays 1, and the new vector is emitted last.
- Misalign and reset mid-operation:
  - Pulse only i_valid_A and i_valid_C. Required: o_misalign=1, count unchanged.
  - Then assert rst while serialising idx=2. Required: all outputs at reset values immediately (asynchronously).
